// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog: single-clock FIFO with arbitrary (non power-of-two) depth,
// occupancy count, programmable almost-full/almost-empty flags and a
// selectable first-word-fall-through read mode.
// Optional feature macro: FIFO_ERR_FLAGS_EN adds clr_err and the sticky
// overflow/underflow flags. Without it, refused accesses are silently dropped.
module fifo_sync_prog #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [CW-1:0]         count
);

  localparam int IW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_THRESH);

  // Reject configurations that would make the flags meaningless.
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_prog: FIFO_DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
    $error("fifo_sync_prog: AF_THRESH must be in 1..FIFO_DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_prog: AE_THRESH must be in 0..FIFO_DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;
  logic [CW-1:0]         count_q;
  logic                  push;
  logic                  pop;

  // Accept decisions use the flags as registered before the edge, so a full
  // FIFO refuses a write even when a pop happens in the same cycle.
  always_comb begin
    push = cs & wr_en & ~full;
    pop  = cs & rd_en & ~empty;
  end

  // All status flags decode from the registered occupancy.
  always_comb begin
    count        = count_q;
    empty        = (count_q == '0);
    full         = (count_q == DEPTH_CNT);
    almost_full  = (count_q >= AF_CNT);
    almost_empty = (count_q <= AE_CNT);
  end

  // Write index wraps explicitly at the last entry, allowing any depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wr_idx <= '0;
    else if (push)
      wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IW'(1);
  end

  // Read index wraps the same way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_idx <= '0;
    else if (pop)
      rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IW'(1);
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else if (push && !pop)
      count_q <= count_q + CW'(1);
    else if (pop && !push)
      count_q <= count_q - CW'(1);
  end

  // Storage array carries no reset; stale words are unreachable after reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_idx] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented combinationally; zero while empty.
    always_comb begin
      data_out = empty ? '0 : mem[rd_idx];
    end
  end else begin : g_reg_read
    // Registered read: popped word appears one cycle after the pop.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        data_out <= '0;
      else if (pop)
        data_out <= mem[rd_idx];
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky overflow: a refused write sets it; a set beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (cs && wr_en && full)
      overflow <= 1'b1;
    else if (clr_err)
      overflow <= 1'b0;
  end

  // Sticky underflow: a refused read sets it; a set beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      underflow <= 1'b0;
    else if (cs && rd_en && empty)
      underflow <= 1'b1;
    else if (clr_err)
      underflow <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: a registered-read and a FWFT instance share the
// same stimulus and are checked against a queue-based reference model.
module tb_fifo_sync_prog;
  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] dout0, dout1;
  logic          empty0, full0, af0, ae0;
  logic          empty1, full1, af1, ae1;
  logic [CW-1:0] count0, count1;
`ifdef FIFO_ERR_FLAGS_EN
  logic          ovf0, unf0, ovf1, unf1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout0 = '0;
  logic          m_ovf = 1'b0, m_unf = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0),
                   .AF_THRESH(AF), .AE_THRESH(AE)) dut0 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(dout0), .empty(empty0), .full(full0),
    .almost_full(af0), .almost_empty(ae0),
`ifdef FIFO_ERR_FLAGS_EN
    .clr_err(clr_err), .overflow(ovf0), .underflow(unf0),
`endif
    .count(count0));

  fifo_sync_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1),
                   .AF_THRESH(AF), .AE_THRESH(AE)) dut1 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(dout1), .empty(empty1), .full(full1),
    .almost_full(af1), .almost_empty(ae1),
`ifdef FIFO_ERR_FLAGS_EN
    .clr_err(clr_err), .overflow(ovf1), .underflow(unf1),
`endif
    .count(count1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, "/count0"}, 32'(count0), n);
    chk({tag, "/count1"}, 32'(count1), n);
    chk({tag, "/empty0"}, 32'(empty0), 32'(n == 0));
    chk({tag, "/empty1"}, 32'(empty1), 32'(n == 0));
    chk({tag, "/full0"},  32'(full0),  32'(n == DEPTH));
    chk({tag, "/full1"},  32'(full1),  32'(n == DEPTH));
    chk({tag, "/af0"},    32'(af0),    32'(n >= AF));
    chk({tag, "/af1"},    32'(af1),    32'(n >= AF));
    chk({tag, "/ae0"},    32'(ae0),    32'(n <= AE));
    chk({tag, "/ae1"},    32'(ae1),    32'(n <= AE));
    chk({tag, "/dout0"},  32'(dout0),  32'(m_dout0));
    chk({tag, "/dout1"},  32'(dout1),  (n > 0) ? 32'(q[0]) : 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    chk({tag, "/ovf0"},   32'(ovf0),   32'(m_ovf));
    chk({tag, "/ovf1"},   32'(ovf1),   32'(m_ovf));
    chk({tag, "/unf0"},   32'(unf0),   32'(m_unf));
    chk({tag, "/unf1"},   32'(unf1),   32'(m_unf));
`endif
  endtask

  // One clock of stimulus; the model applies the access rules to the
  // pre-edge occupancy, then every output is compared 1 time unit later.
  task automatic cycle(input string tag, input logic c, input logic w, input logic r,
                       input logic [DW-1:0] d, input logic clr);
    bit do_push, do_pop, ovf_set, unf_set;
    cs = c; wr_en = w; rd_en = r; data_in = d; clr_err = clr;
    do_push = c && w && (q.size() < DEPTH);
    do_pop  = c && r && (q.size() > 0);
    ovf_set = c && w && (q.size() == DEPTH);
    unf_set = c && r && (q.size() == 0);
    @(posedge clk);
    if (do_pop)  m_dout0 = q.pop_front();
    if (do_push) q.push_back(d);
    m_ovf = ovf_set | (m_ovf & ~clr);
    m_unf = unf_set | (m_unf & ~clr);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_dout0 = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] held;

    // Reset state.
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full, then drain with 1-cycle registered latency.
    for (int i = 0; i < DEPTH; i++) cycle("t1_push", 1, 1, 0, 8'hA0 + 8'(i), 0);
    chk("t1_full_lit", 32'(full0), 32'd1);
    chk("t1_count_lit", 32'(count0), 32'd5);
    for (int i = 0; i < DEPTH; i++) begin
      cycle("t1_pop", 1, 0, 1, 8'h00, 0);
      chk("t1_dout_lit", 32'(dout0), 32'hA0 + 32'(i));
    end
    chk("t1_empty_lit", 32'(empty0), 32'd1);

    // Interleaved push/pop traffic wrapping the indices.
    for (int i = 0; i < 12; i++)
      cycle("t2_mix", 1, (i % 3) != 2, (i % 2) == 1, 8'h30 + 8'(i), 0);

    // Full: write refused while a pop is accepted.
    while (q.size() < DEPTH) cycle("t3_fill", 1, 1, 0, 8'($urandom), 0);
    cycle("t3_full_both", 1, 1, 1, 8'hFF, 0);
    chk("t3_count_lit", 32'(count0), 32'd4);
    while (q.size() > 0) cycle("t3_drain", 1, 0, 1, 8'h00, 0);
    for (int i = 0; i < DEPTH - 1; i++) chk("t3_no_ff", 32'(dout0 == 8'hFF), 32'd0);
    // Empty: read refused while a push is accepted.
    held = dout0;
    cycle("t3_empty_both", 1, 1, 1, 8'h11, 0);
    chk("t3_count1_lit", 32'(count0), 32'd1);
    chk("t3_dout_held", 32'(dout0), 32'(held));
    chk("t4_fwft_lit", 32'(dout1), 32'h11);
    cycle("t4_pop", 1, 0, 1, 8'h00, 0);
    chk("t4_fwft_zero", 32'(dout1), 32'd0);

    // Threshold sweep 0..5 and chip-select gating.
    for (int i = 0; i < DEPTH; i++) cycle("t5_fill", 1, 1, 0, 8'h50 + 8'(i), 0);
    cycle("t5_cs_low", 0, 1, 1, 8'hEE, 0);
    chk("t5_cs_count", 32'(count0), 32'd5);
    while (q.size() > 0) cycle("t5_drain", 1, 0, 1, 8'h00, 0);

    // Randomized traffic in phases biased towards filling, draining, mixing.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 80; i++) begin
        logic c, w, r, clr;
        c   = ($urandom_range(0, 7) != 0);
        w   = ($urandom_range(0, 9) < ((ph % 3 == 0) ? 8 : (ph % 3 == 1) ? 2 : 5));
        r   = ($urandom_range(0, 9) < ((ph % 3 == 0) ? 2 : (ph % 3 == 1) ? 8 : 5));
        clr = ($urandom_range(0, 15) == 0);
        cycle("rand", c, w, r, 8'($urandom), clr);
      end
    end

    // Asynchronous reset mid-burst at count 3.
    while (q.size() > 0) cycle("t6_drain", 1, 0, 1, 8'h00, 0);
    for (int i = 0; i < 3; i++) cycle("t6_fill", 1, 1, 0, 8'h60 + 8'(i), 0);
    cycle("t6_pop", 1, 0, 1, 8'h00, 0);
    cycle("t6_push", 1, 1, 0, 8'h63, 0);
    chk("t6_count3", 32'(count0), 32'd3);
    cs = 1'b1; wr_en = 1'b1; rd_en = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("t6_async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("t6_after_rst", 1, 1, 0, 8'h77, 0);

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky overflow/underflow, set wins over clear.
    while (q.size() < DEPTH) cycle("err_fill", 1, 1, 0, 8'($urandom), 0);
    cycle("err_ovf", 1, 1, 0, 8'h99, 0);
    chk("err_ovf_lit", 32'(ovf0), 32'd1);
    cycle("err_idle", 0, 0, 0, 8'h00, 0);
    chk("err_ovf_hold", 32'(ovf0), 32'd1);
    cycle("err_set_clr", 1, 1, 0, 8'h99, 1);
    chk("err_set_wins", 32'(ovf0), 32'd1);
    cycle("err_clr", 0, 0, 0, 8'h00, 1);
    chk("err_ovf_clr", 32'(ovf0), 32'd0);
    while (q.size() > 0) cycle("err_drain", 1, 0, 1, 8'h00, 0);
    cycle("err_unf", 1, 0, 1, 8'h00, 0);
    chk("err_unf_lit", 32'(unf0), 32'd1);
    cycle("err_clr2", 0, 0, 0, 8'h00, 1);
    chk("err_unf_clr", 32'(unf0), 32'd0);
`endif

    cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
